// File: rtl/registerfile_mp.sv
// Two-write / two-read register file with a per-register busy scoreboard.
// Reads are combinational (with optional write forwarding); writes and reserves are synchronous.
module registerfile_mp #(
    parameter int DataWidth = 16,
    parameter int AddWidth  = 3,
    parameter int ZeroReg   = 1,
    parameter int Bypass    = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [AddWidth-1:0]  ADD1,
    input  logic [AddWidth-1:0]  ADD2,
    output logic [DataWidth-1:0] R1,
    output logic [DataWidth-1:0] R2,
    output logic                 BUSY1,
    output logic                 BUSY2,
    input  logic                 WEN0,
    input  logic [AddWidth-1:0]  WADD0,
    input  logic [DataWidth-1:0] DATAIN0,
    input  logic                 WEN1,
    input  logic [AddWidth-1:0]  WADD1,
    input  logic [DataWidth-1:0] DATAIN1,
    input  logic                 RSV,
    input  logic [AddWidth-1:0]  RSVADD,
    output logic                 RSVOK
);

    localparam int Depth    = 1 << AddWidth;
    localparam bit ZeroEn   = (ZeroReg != 0);
    localparam bit BypassEn = (Bypass != 0);

    logic [DataWidth-1:0] r_mem [Depth];
    logic [Depth-1:0]     r_busy;

    logic                 w_we0;
    logic                 w_we1;
    logic                 w_rsv_accept;
    logic [DataWidth:0]   w_rd1;
    logic [DataWidth:0]   w_rd2;

    function automatic logic is_zero_addr(input logic [AddWidth-1:0] addr);
        return ZeroEn && (addr == {AddWidth{1'b0}});
    endfunction

    // Returns {busy, data} for one read port; reset and the zero register override forwarding.
    function automatic logic [DataWidth:0] read_port(
        input logic                 rst_ok,
        input logic [AddWidth-1:0]  addr,
        input logic [DataWidth-1:0] mem_val,
        input logic                 busy_val,
        input logic                 wen0,
        input logic [AddWidth-1:0]  wadd0,
        input logic [DataWidth-1:0] din0,
        input logic                 wen1,
        input logic [AddWidth-1:0]  wadd1,
        input logic [DataWidth-1:0] din1
    );
        logic [DataWidth-1:0] data;
        logic                 busy;
        logic                 hit0;
        logic                 hit1;
        hit1 = BypassEn && wen1 && (wadd1 == addr);
        hit0 = BypassEn && wen0 && (wadd0 == addr);
        if (hit1) begin
            data = din1;
        end else if (hit0) begin
            data = din0;
        end else begin
            data = mem_val;
        end
        if (hit0 || hit1) begin
            busy = 1'b0;
        end else begin
            busy = busy_val;
        end
        if (!rst_ok || is_zero_addr(addr)) begin
            data = {DataWidth{1'b0}};
            busy = 1'b0;
        end else begin
            data = data;
        end
        return {busy, data};
    endfunction

    // Qualify write ports (port 1 wins collisions, zero register drops writes) and accept reserves.
    always_comb begin
        w_we1        = WEN1 && !is_zero_addr(WADD1);
        w_we0        = WEN0 && !is_zero_addr(WADD0) && !(WEN1 && (WADD1 == WADD0));
        w_rsv_accept = RSV && RESET_N && !r_busy[RSVADD] && !is_zero_addr(RSVADD);
    end

    // Storage and scoreboard update; an accepted reserve beats a same-address write on BUSY.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= {DataWidth{1'b0}};
            end
            r_busy <= {Depth{1'b0}};
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (w_we1 && (WADD1 == AddWidth'(i))) begin
                    r_mem[i] <= DATAIN1;
                end else if (w_we0 && (WADD0 == AddWidth'(i))) begin
                    r_mem[i] <= DATAIN0;
                end
                if (w_rsv_accept && (RSVADD == AddWidth'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if ((w_we1 && (WADD1 == AddWidth'(i))) ||
                             (w_we0 && (WADD0 == AddWidth'(i)))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Combinational read ports.
    always_comb begin
        w_rd1 = read_port(RESET_N, ADD1, r_mem[ADD1], r_busy[ADD1],
                          WEN0, WADD0, DATAIN0, WEN1, WADD1, DATAIN1);
        w_rd2 = read_port(RESET_N, ADD2, r_mem[ADD2], r_busy[ADD2],
                          WEN0, WADD0, DATAIN0, WEN1, WADD1, DATAIN1);
    end

    assign R1    = w_rd1[DataWidth-1:0];
    assign BUSY1 = w_rd1[DataWidth];
    assign R2    = w_rd2[DataWidth-1:0];
    assign BUSY2 = w_rd2[DataWidth];
    assign RSVOK = w_rsv_accept;

endmodule

// File: tb/tb_registerfile_mp.sv
// Directed scoreboard bench: instance A (ZeroReg=1, Bypass=1) and instance B (ZeroReg=0, Bypass=0)
// share all inputs; expected outputs of both are queued per step and compared mid-cycle.
module tb_registerfile_mp;

    logic        clk;
    logic        rst_n;
    logic [2:0]  add1, add2;
    logic        wen0, wen1, rsv;
    logic [2:0]  wadd0, wadd1, rsvadd;
    logic [15:0] din0, din1;

    logic [15:0] a_r1, a_r2, b_r1, b_r2;
    logic        a_b1, a_b2, a_ok, b_b1, b_b2, b_ok;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        bit          sel_b;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [2:0]  flags;
    } exp_t;

    exp_t sb[$];

    registerfile_mp #(.DataWidth(16), .AddWidth(3), .ZeroReg(1), .Bypass(1)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .ADD1(add1), .ADD2(add2),
        .R1(a_r1), .R2(a_r2), .BUSY1(a_b1), .BUSY2(a_b2),
        .WEN0(wen0), .WADD0(wadd0), .DATAIN0(din0),
        .WEN1(wen1), .WADD1(wadd1), .DATAIN1(din1),
        .RSV(rsv), .RSVADD(rsvadd), .RSVOK(a_ok)
    );

    registerfile_mp #(.DataWidth(16), .AddWidth(3), .ZeroReg(0), .Bypass(0)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .ADD1(add1), .ADD2(add2),
        .R1(b_r1), .R2(b_r2), .BUSY1(b_b1), .BUSY2(b_b2),
        .WEN0(wen0), .WADD0(wadd0), .DATAIN0(din0),
        .WEN1(wen1), .WADD1(wadd1), .DATAIN1(din1),
        .RSV(rsv), .RSVADD(rsvadd), .RSVOK(b_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed %h expected %h", tag, fld, obs, exp);
        end
    endtask

    // flags = {BUSY1, BUSY2, RSVOK}
    task automatic push(input string tag,
                        input logic [15:0] ar1, input logic [15:0] ar2, input logic [2:0] af,
                        input logic [15:0] br1, input logic [15:0] br2, input logic [2:0] bf);
        exp_t e;
        e.tag = {tag, "/A"}; e.sel_b = 1'b0; e.r1 = ar1; e.r2 = ar2; e.flags = af;
        sb.push_back(e);
        e.tag = {tag, "/B"}; e.sel_b = 1'b1; e.r1 = br1; e.r2 = br2; e.flags = bf;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel_b) begin
                cmp(e.tag, "R1", b_r1, e.r1);
                cmp(e.tag, "R2", b_r2, e.r2);
                cmp(e.tag, "BUSY1", {15'd0, b_b1}, {15'd0, e.flags[2]});
                cmp(e.tag, "BUSY2", {15'd0, b_b2}, {15'd0, e.flags[1]});
                cmp(e.tag, "RSVOK", {15'd0, b_ok}, {15'd0, e.flags[0]});
            end else begin
                cmp(e.tag, "R1", a_r1, e.r1);
                cmp(e.tag, "R2", a_r2, e.r2);
                cmp(e.tag, "BUSY1", {15'd0, a_b1}, {15'd0, e.flags[2]});
                cmp(e.tag, "BUSY2", {15'd0, a_b2}, {15'd0, e.flags[1]});
                cmp(e.tag, "RSVOK", {15'd0, a_ok}, {15'd0, e.flags[0]});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    task automatic drive(input logic w0, input logic [2:0] a0, input logic [15:0] d0,
                         input logic w1, input logic [2:0] a1, input logic [15:0] d1,
                         input logic rv, input logic [2:0] ra);
        wen0 = w0; wadd0 = a0; din0 = d0;
        wen1 = w1; wadd1 = a1; din1 = d1;
        rsv = rv; rsvadd = ra;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    endtask

    initial begin
        // Reset held: writes and reserves ignored, outputs zero
        rst_n = 1'b0; add1 = 3'd3; add2 = 3'd4;
        drive(1'b1, 3'd3, 16'hAAAA, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4);
        repeat (3) tick();
        push("reset_hold", 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000, 3'b000);
        settle();

        // Release and first write
        rst_n = 1'b1;
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        push("wr_same", 16'h1234, 16'h0000, 3'b000, 16'h0000, 16'h0000, 3'b000);
        settle();
        tick(); idle();
        push("wr_next", 16'h1234, 16'h0000, 3'b000, 16'h1234, 16'h0000, 3'b000);
        settle();

        // Dual-write collision: port 1 wins
        add1 = 3'd5; add2 = 3'd3;
        drive(1'b1, 3'd5, 16'h1111, 1'b1, 3'd5, 16'h2222, 1'b0, 3'd0);
        push("coll_same", 16'h2222, 16'h1234, 3'b000, 16'h0000, 16'h1234, 3'b000);
        settle();
        tick(); idle();
        push("coll_next", 16'h2222, 16'h1234, 3'b000, 16'h2222, 16'h1234, 3'b000);
        settle();

        // Distinct addresses on both ports
        add1 = 3'd2; add2 = 3'd6;
        drive(1'b1, 3'd2, 16'h2C2C, 1'b1, 3'd6, 16'h6E6E, 1'b0, 3'd0);
        push("dual_same", 16'h2C2C, 16'h6E6E, 3'b000, 16'h0000, 16'h0000, 3'b000);
        settle();
        tick(); idle();
        push("dual_next", 16'h2C2C, 16'h6E6E, 3'b000, 16'h2C2C, 16'h6E6E, 3'b000);
        settle();

        // Zero register: both ports and a reserve aimed at reg 0
        add1 = 3'd0; add2 = 3'd5;
        drive(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0);
        push("zero_same", 16'h0000, 16'h2222, 3'b000, 16'h0000, 16'h2222, 3'b001);
        settle();
        tick(); idle();
        push("zero_next", 16'h0000, 16'h2222, 3'b000, 16'hFFFF, 16'h2222, 3'b100);
        settle();

        // Scoreboard on reg 4
        add1 = 3'd4; add2 = 3'd0;
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4);
        push("rsv_first", 16'h0000, 16'h0000, 3'b001, 16'h0000, 16'hFFFF, 3'b011);
        settle();
        tick();
        push("rsv_again", 16'h0000, 16'h0000, 3'b100, 16'h0000, 16'hFFFF, 3'b110);
        settle();
        tick();
        drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h4141, 1'b0, 3'd0);
        push("wr_clears", 16'h4141, 16'h0000, 3'b000, 16'h0000, 16'hFFFF, 3'b110);
        settle();
        tick();
        drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h4444, 1'b1, 3'd4);
        push("wr_rsv_same", 16'h4444, 16'h0000, 3'b001, 16'h4141, 16'hFFFF, 3'b011);
        settle();
        tick(); idle();
        push("wr_rsv_next", 16'h4444, 16'h0000, 3'b100, 16'h4444, 16'hFFFF, 3'b110);
        settle();
        drive(1'b1, 3'd4, 16'h4545, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        push("lone_same", 16'h4545, 16'h0000, 3'b000, 16'h4444, 16'hFFFF, 3'b110);
        settle();
        tick(); idle();
        push("lone_next", 16'h4545, 16'h0000, 3'b000, 16'h4545, 16'hFFFF, 3'b010);
        settle();

        // Bypass priority on a reserved reg 7
        add1 = 3'd7; add2 = 3'd7;
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd7);
        push("rsv7", 16'h0000, 16'h0000, 3'b001, 16'h0000, 16'h0000, 3'b001);
        settle();
        tick();
        drive(1'b1, 3'd7, 16'h0A0A, 1'b1, 3'd7, 16'h0B0B, 1'b0, 3'd0);
        push("byp_prio", 16'h0B0B, 16'h0B0B, 3'b000, 16'h0000, 16'h0000, 3'b110);
        settle();
        tick(); idle();
        push("byp_next", 16'h0B0B, 16'h0B0B, 3'b000, 16'h0B0B, 16'h0B0B, 3'b000);
        settle();

        // Async reset between edges with reg 2 busy and a write pending
        add1 = 3'd2; add2 = 3'd6;
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2);
        push("rsv2", 16'h2C2C, 16'h6E6E, 3'b001, 16'h2C2C, 16'h6E6E, 3'b001);
        settle();
        tick();
        drive(1'b1, 3'd6, 16'hDEAD, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        push("pend", 16'h2C2C, 16'hDEAD, 3'b100, 16'h2C2C, 16'h6E6E, 3'b100);
        settle();
        #1 rst_n = 1'b0;
        push("async_rst", 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000, 3'b000);
        settle();
        tick();
        rst_n = 1'b1; idle();
        push("post_rst", 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000, 3'b000);
        settle();
        tick();
        push("pend_lost", 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000, 3'b000);
        settle();
        drive(1'b1, 3'd6, 16'h600D, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        push("rewr_same", 16'h0000, 16'h600D, 3'b000, 16'h0000, 16'h0000, 3'b000);
        settle();
        tick(); idle();
        push("rewr_next", 16'h0000, 16'h600D, 3'b000, 16'h0000, 16'h600D, 3'b000);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
